issue_queue: RTL and testbench

//  Parametrised out-of-order issue buffer sitting between DEC and the d2e pipeline register.

---
 rtl/ooo_pkg.sv | 15 +
 rtl/iq_select.sv | 22 ++
 rtl/issue_queue.sv | 154 +++++++++++++++
 tb/tb_issue_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order issue buffer.
// IQ_REG_W is the widest register address an iq_entry_t can hold.
package ooo_pkg;

    localparam int IQ_REG_W = 5;
    localparam int NUM_SRC  = 2;

    // Payload is carried in a separate array so this type stays width-independent.
    typedef struct packed {
        logic                               valid;
        logic [NUM_SRC-1:0]                 src_rdy;
        logic [NUM_SRC-1:0][IQ_REG_W-1:0]   src;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Find-first priority encoder: lowest set request bit wins.
module iq_select #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue: holds decoded instructions until both sources are
// ready, issues the oldest ready one per cycle. REG_W must not exceed IQ_REG_W.
module issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 2,
    parameter int PAYLOAD_W  = 64,
    parameter int REG_W      = IQ_REG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_enq_valid,
    output logic                        o_enq_ready,
    input  logic [PAYLOAD_W-1:0]        i_enq_payload,
    input  logic [2*REG_W-1:0]          i_enq_src,
    input  logic [1:0]                  i_enq_src_rdy,
    input  logic [WAKE_PORTS-1:0]       i_wake_valid,
    input  logic [WAKE_PORTS*REG_W-1:0] i_wake_addr,
    output logic                        o_iss_valid,
    input  logic                        i_iss_ready,
    output logic [PAYLOAD_W-1:0]        o_iss_payload,
    output logic [$clog2(DEPTH+1)-1:0]  o_count,
    output logic                        o_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t            ent_q [DEPTH];
    iq_entry_t            ent_d [DEPTH];
    iq_entry_t            woken [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;

    logic [DEPTH-1:0] rdy_vec;
    logic [IW-1:0]    sel_idx;
    logic             sel_found;
    logic             iss_fire, enq_fire;
    logic [CW-1:0]    wr_idx;
    iq_entry_t        new_ent;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].valid & (&ent_q[i].src_rdy);
        end
    end

    iq_select #(.N(DEPTH), .IW(IW)) u_select (
        .i_req   (rdy_vec),
        .o_idx   (sel_idx),
        .o_found (sel_found)
    );

    // Ready comes from the registered count only, so no path from i_iss_ready.
    assign o_enq_ready   = (count_q != CW'(DEPTH));
    assign o_full        = (count_q == CW'(DEPTH));
    assign o_count       = count_q;
    assign o_iss_valid   = sel_found & ~i_flush;
    assign o_iss_payload = pay_q[sel_idx];
    assign iss_fire      = o_iss_valid & i_iss_ready;
    assign enq_fire      = i_enq_valid & o_enq_ready & ~i_flush;
    assign wr_idx        = count_q - CW'(iss_fire);

    always_comb begin
        logic [REG_W-1:0] wa;
        logic [REG_W-1:0] es;
        // Wakeup of stored entries; r0 broadcasts are meaningless and skipped.
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int p = 0; p < WAKE_PORTS; p++) begin
                    wa = i_wake_addr[p*REG_W +: REG_W];
                    if (ent_q[i].valid && i_wake_valid[p] && wa != '0 &&
                        ent_q[i].src[s] == IQ_REG_W'(wa)) begin
                        woken[i].src_rdy[s] = 1'b1;
                    end
                end
            end
        end

        new_ent       = '0;
        new_ent.valid = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            es               = i_enq_src[s*REG_W +: REG_W];
            new_ent.src[s]   = IQ_REG_W'(es);
            new_ent.src_rdy[s] = i_enq_src_rdy[s] | (es == '0);
            for (int p = 0; p < WAKE_PORTS; p++) begin
                wa = i_wake_addr[p*REG_W +: REG_W];
                if (i_wake_valid[p] && wa != '0 && wa == es) begin
                    new_ent.src_rdy[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woken[i];
            pay_d[i] = pay_q[i];
        end
        count_d = count_q + CW'(enq_fire) - CW'(iss_fire);

        // Collapse: everything above the issued slot moves down one, keeping age order.
        if (iss_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = woken[i+1];
                    pay_d[i] = pay_q[i+1];
                end
            end
            ent_d[DEPTH-1].valid = 1'b0;
        end

        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_d[i] = new_ent;
                    pay_d[i] = i_enq_payload;
                end
            end
        end

        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            pay_q[i] <= pay_d[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the buffer contents.
module tb_issue_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush, i_enq_valid, i_iss_ready;
    logic        o_enq_ready, o_iss_valid, o_full;
    logic [63:0] i_enq_payload, o_iss_payload;
    logic [9:0]  i_enq_src, i_wake_addr;
    logic [1:0]  i_enq_src_rdy, i_wake_valid;
    logic [3:0]  o_count;

    issue_queue #(.DEPTH(DEPTH), .WAKE_PORTS(2), .PAYLOAD_W(64), .REG_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_enq_valid   (i_enq_valid),
        .o_enq_ready   (o_enq_ready),
        .i_enq_payload (i_enq_payload),
        .i_enq_src     (i_enq_src),
        .i_enq_src_rdy (i_enq_src_rdy),
        .i_wake_valid  (i_wake_valid),
        .i_wake_addr   (i_wake_addr),
        .o_iss_valid   (o_iss_valid),
        .i_iss_ready   (i_iss_ready),
        .o_iss_payload (o_iss_payload),
        .o_count       (o_count),
        .o_full        (o_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]     pay;
        logic [1:0][4:0] src;
        logic [1:0]      rdy;
    } ment_t;

    ment_t       mq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_iv, last_er;
    logic [63:0] last_pay;
    int          last_cnt;
    logic [63:0] pc = 64'h1000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, compare against the model,
    // then advance the model to what the next edge must produce.
    task automatic step(input logic fl, input logic ev, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] rdy, input logic [1:0] wv, input logic [4:0] w0,
                        input logic [4:0] w1, input logic ir);
        int    sel;
        logic  exp_iv, do_enq, do_iss;
        ment_t e;
        logic [4:0] wa [2];
        @(negedge clk);
        pc            = pc + 1;
        i_flush       = fl;
        i_enq_valid   = ev;
        i_enq_payload = pc;
        i_enq_src     = {s1, s0};
        i_enq_src_rdy = rdy;
        i_wake_valid  = wv;
        i_wake_addr   = {w1, w0};
        i_iss_ready   = ir;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].rdy == 2'b11) sel = i;
        exp_iv = !fl && sel >= 0;
        chk("iss_valid", o_iss_valid, exp_iv);
        if (exp_iv) chk("iss_payload", o_iss_payload, mq[sel].pay);
        chk("count", o_count, mq.size());
        chk("full", o_full, mq.size() == DEPTH);
        chk("enq_ready", o_enq_ready, mq.size() < DEPTH);
        last_iv  = o_iss_valid;
        last_er  = o_enq_ready;
        last_pay = o_iss_payload;
        last_cnt = o_count;

        wa[0] = w0;
        wa[1] = w1;
        if (fl) begin
            mq.delete();
        end else begin
            do_enq = ev && mq.size() < DEPTH;
            do_iss = exp_iv && ir;
            if (do_iss) mq.delete(sel);
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                for (int s = 0; s < 2; s++)
                    for (int p = 0; p < 2; p++)
                        if (wv[p] && wa[p] != 0 && e.src[s] == wa[p]) e.rdy[s] = 1'b1;
                mq[i] = e;
            end
            if (do_enq) begin
                e.pay    = pc;
                e.src[0] = s0;
                e.src[1] = s1;
                for (int s = 0; s < 2; s++) begin
                    e.rdy[s] = rdy[s] || e.src[s] == 0;
                    for (int p = 0; p < 2; p++)
                        if (wv[p] && wa[p] != 0 && e.src[s] == wa[p]) e.rdy[s] = 1'b1;
                end
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 2'b00, 5'd0, 5'd0, ir);
    endtask

    task automatic enq_rdy(input logic ir);
        step(1'b0, 1'b1, 5'd1, 5'd2, 2'b11, 2'b00, 5'd0, 5'd0, ir);
    endtask

    logic [63:0] pa, pb;

    initial begin
        rst = 1'b1; i_flush = 0; i_enq_valid = 0; i_iss_ready = 0;
        i_enq_payload = '0; i_enq_src = '0; i_enq_src_rdy = '0;
        i_wake_valid = '0; i_wake_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", o_count, 0);
        chk("reset_iss_valid", o_iss_valid, 0);
        chk("reset_enq_ready", o_enq_ready, 1);
        chk("reset_full", o_full, 0);
        rst = 1'b0;

        // Three ready instructions issue in order, one cycle after each enqueue.
        enq_rdy(1'b1); pa = pc;
        chk("t1_no_same_cycle_issue", last_iv, 0);
        enq_rdy(1'b1);
        chk("t1_first_pay", last_pay, pa);
        enq_rdy(1'b1);
        chk("t1_second_pay", last_pay, pa + 1);
        idle(1'b1);
        chk("t1_third_pay", last_pay, pa + 2);
        idle(1'b1);
        chk("t1_drained", last_cnt, 0);

        // A waits on r5, B is ready: B overtakes, A issues after wakeup registers.
        step(1'b0, 1'b1, 5'd5, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 1'b1); pa = pc;
        enq_rdy(1'b1); pb = pc;
        chk("t2_nothing_ready", last_iv, 0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b01, 5'd5, 5'd0, 1'b1);
        chk("t2_b_first", last_pay, pb);
        idle(1'b1);
        chk("t2_a_valid", last_iv, 1);
        chk("t2_a_pay", last_pay, pa);

        // Fill to DEPTH with issue blocked.
        for (int i = 0; i < DEPTH; i++) enq_rdy(1'b0);
        enq_rdy(1'b0);
        chk("t3_count_full", last_cnt, DEPTH);
        chk("t3_enq_ready_low", last_er, 0);
        enq_rdy(1'b1);
        chk("t3_issue_when_full", last_iv, 1);
        enq_rdy(1'b0);
        chk("t3_count_after_issue", last_cnt, DEPTH - 1);
        idle(1'b0);
        chk("t3_refilled", last_cnt, DEPTH);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        idle(1'b1);
        chk("t3_empty", last_cnt, 0);

        // Same-cycle wakeup on port 1 at enqueue.
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b00, 2'b10, 5'd0, 5'd7, 1'b1); pa = pc;
        idle(1'b1);
        chk("t4_bypass_issue", last_pay, pa);
        step(1'b0, 1'b1, 5'd3, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 1'b1); pa = pc;
        step(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b11, 5'd0, 5'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b01, 5'd3, 5'd0, 1'b1);
        chk("t4_r0_wake_ignored", last_iv, 0);
        idle(1'b1);
        chk("t4_r3_woken", last_pay, pa);

        // Flush with enqueue and issue in the same cycle.
        for (int i = 0; i < 5; i++) enq_rdy(1'b0);
        step(1'b1, 1'b1, 5'd0, 5'd0, 2'b11, 2'b00, 5'd0, 5'd0, 1'b1);
        chk("t5_flush_no_issue", last_iv, 0);
        idle(1'b1);
        chk("t5_flush_count", last_cnt, 0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) enq_rdy(1'b0);
        @(negedge clk);
        i_enq_valid = 0; i_iss_ready = 1;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", o_count, 0);
        chk("t6_async_iss_valid", o_iss_valid, 0);
        chk("t6_async_enq_ready", o_enq_ready, 1);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        chk("t6_count_after_release", last_cnt, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
